led_mode_controller: RTL

//  Button-driven controller for the green-LED blinker. Debounces KEY[3:0] and

---
 rtl/led_mode_controller_pkg.sv | 43 ++++
 rtl/led_mode_controller_if.sv | 31 +++
 rtl/led_mode_controller_key_debounce.sv | 71 +++++++
 rtl/led_mode_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/led_mode_controller_pkg.sv
// Shared types and constants for the LED mode controller: pattern modes,
// bounce direction, rate limits, entry patterns and key roles.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK   = 2'd0,
        MODE_SHIFT_L = 2'd1,
        MODE_SHIFT_R = 2'd2,
        MODE_BOUNCE  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [1:0] RATE_MAX = 2'd3;
    localparam logic [1:0] RATE_MIN = 2'd0;

    // Patterns loaded the cycle a mode is entered (8-LED board layout)
    localparam logic [7:0] LED_ENTRY_BLINK   = 8'h00;
    localparam logic [7:0] LED_ENTRY_SHIFT_L = 8'h01;
    localparam logic [7:0] LED_ENTRY_SHIFT_R = 8'h80;
    localparam logic [7:0] LED_ENTRY_BOUNCE  = 8'h01;

    // Which push-button drives which command
    localparam int KEY_UP   = 0;
    localparam int KEY_DN   = 1;
    localparam int KEY_MODE = 2;
    localparam int KEY_RUN  = 3;

    // Mode sequence advanced by the mode key; wraps from BOUNCE to BLINK
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_BLINK:   return MODE_SHIFT_L;
            MODE_SHIFT_L: return MODE_SHIFT_R;
            MODE_SHIFT_R: return MODE_BOUNCE;
            MODE_BOUNCE:  return MODE_BLINK;
            default:      return MODE_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/led_mode_controller_if.sv
// Board-side bundle of the controller: raw keys in, LED pattern and status out.
interface led_mode_controller_if #(
    parameter int NLED = 8
);
    logic [3:0]      KEY;
    logic [NLED-1:0] LEDG;
    logic [1:0]      RATE_IDX;
    logic [1:0]      MODE;
    logic            RUNNING;
    logic            TICK;

    // Board / stimulus side: drives the buttons, watches the LEDs
    modport master (
        output KEY,
        input  LEDG,
        input  RATE_IDX,
        input  MODE,
        input  RUNNING,
        input  TICK
    );

    // Controller side
    modport slave (
        input  KEY,
        output LEDG,
        output RATE_IDX,
        output MODE,
        output RUNNING,
        output TICK
    );
endinterface

// File: rtl/led_mode_controller_key_debounce.sv
// One push-button: two-flop synchronizer, stability counter and press
// detector. A new level is accepted only after DEBOUNCE_CYC consecutive
// synchronized samples that all differ from the currently accepted level;
// a single sample back at the accepted level restarts the count. A press is
// a one-cycle pulse on an accepted released->pressed transition.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Bring the asynchronous button into the clock domain; idle is released
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples away from the accepted level and flip on the last one
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
            press_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Debounce state; press is registered so it is exactly one cycle wide
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/led_mode_controller.sv
// Button-driven LED blinker controller. Four debounced keys issue rate, mode
// and run/pause commands; a fractional accumulator paces a pattern FSM that
// drives the green LEDs. All outputs come straight from registers.
module led_mode_controller
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int BASE_PERIOD  = 50_000_000,
    parameter int NLED         = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    led_mode_controller_if.slave  bus
);

    localparam int AW = $clog2(BASE_PERIOD) + 1;
    localparam logic [AW:0]     PERIOD_EXT = (AW+1)'(BASE_PERIOD);
    localparam logic [AW:0]     STEP_ONE   = (AW+1)'(1);
    localparam logic [NLED-1:0] LED_MSB    = {1'b1, {(NLED-1){1'b0}}};
    localparam logic [NLED-1:0] ENTRY_L    = NLED'(LED_ENTRY_SHIFT_L);
    localparam logic [NLED-1:0] ENTRY_R    = (NLED == 8) ? NLED'(LED_ENTRY_SHIFT_R) : LED_MSB;
    localparam logic [NLED-1:0] ENTRY_BLK  = NLED'(LED_ENTRY_BLINK);
    localparam logic [NLED-1:0] ENTRY_BNC  = NLED'(LED_ENTRY_BOUNCE);

    logic [3:0]      key_level_s;
    logic [3:0]      key_press_s;
    logic [3:0]      press_ok_s;
    logic            cmd_run_s;
    logic            cmd_mode_s;
    logic            cmd_dn_s;
    logic            cmd_up_s;
    logic            rate_up_s;
    logic            rate_dn_s;
    logic [AW:0]     acc_sum_s;

    logic [1:0]      rate_q;
    logic [1:0]      rate_d;
    mode_t           mode_q;
    mode_t           mode_d;
    logic            running_q;
    logic            running_d;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_d;
    logic            tick_q;
    logic            tick_d;
    logic [NLED-1:0] led_q;
    dir_t            dir_q;

    // One debouncer per push-button
    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .CLOCK_50 (CLOCK_50),
            .RESET_N  (RESET_N),
            .key_n    (bus.KEY[k]),
            .level    (key_level_s[k]),
            .press    (key_press_s[k])
        );
    end

    // Pick the single highest-priority press; lower ones in the same cycle are dropped
    always_comb begin
        press_ok_s = key_press_s & ~key_level_s;
        cmd_run_s  = press_ok_s[KEY_RUN];
        cmd_mode_s = press_ok_s[KEY_MODE] & ~press_ok_s[KEY_RUN];
        cmd_dn_s   = press_ok_s[KEY_DN] & ~press_ok_s[KEY_RUN] & ~press_ok_s[KEY_MODE];
        cmd_up_s   = press_ok_s[KEY_UP] & ~press_ok_s[KEY_RUN] & ~press_ok_s[KEY_MODE]
                   & ~press_ok_s[KEY_DN];
        rate_up_s  = cmd_up_s & (rate_q != RATE_MAX);
        rate_dn_s  = cmd_dn_s & (rate_q != RATE_MIN);
        acc_sum_s  = {1'b0, acc_q} + (STEP_ONE << rate_q);
    end

    // Command execution and tick accumulator. A cycle that executes a
    // command does not step the accumulator; a saturated rate press is
    // not a command and lets the accumulator step normally.
    always_comb begin
        rate_d    = rate_q;
        mode_d    = mode_q;
        running_d = running_q;
        acc_d     = acc_q;
        tick_d    = 1'b0;
        if (cmd_run_s) begin
            running_d = ~running_q;
        end else if (cmd_mode_s) begin
            mode_d = next_mode(mode_q);
            acc_d  = '0;
        end else if (rate_up_s) begin
            rate_d = rate_q + 2'd1;
            acc_d  = '0;
        end else if (rate_dn_s) begin
            rate_d = rate_q - 2'd1;
            acc_d  = '0;
        end else if (running_q) begin
            if (acc_sum_s >= PERIOD_EXT) begin
                acc_d  = AW'(acc_sum_s - PERIOD_EXT);
                tick_d = 1'b1;
            end else begin
                acc_d = AW'(acc_sum_s);
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Control and tick registers
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rate_q    <= 2'd0;
            mode_q    <= MODE_BLINK;
            running_q <= 1'b1;
            acc_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            rate_q    <= rate_d;
            mode_q    <= mode_d;
            running_q <= running_d;
            acc_q     <= acc_d;
            tick_q    <= tick_d;
        end
    end

    // Pattern FSM: load the entry pattern on a mode change, otherwise step on tick
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            led_q <= '0;
            dir_q <= DIR_LEFT;
        end else if (cmd_mode_s) begin
            dir_q <= DIR_LEFT;
            case (mode_d)
                MODE_BLINK:   led_q <= ENTRY_BLK;
                MODE_SHIFT_L: led_q <= ENTRY_L;
                MODE_SHIFT_R: led_q <= ENTRY_R;
                MODE_BOUNCE:  led_q <= ENTRY_BNC;
                default:      led_q <= ENTRY_BLK;
            endcase
        end else if (tick_d) begin
            case (mode_q)
                MODE_BLINK: begin
                    led_q <= ~led_q;
                end
                MODE_SHIFT_L: begin
                    led_q <= {led_q[NLED-2:0], led_q[NLED-1]};
                end
                MODE_SHIFT_R: begin
                    led_q <= {led_q[0], led_q[NLED-1:1]};
                end
                MODE_BOUNCE: begin
                    // Turn around on the end LED in the same tick so no end repeats
                    if (dir_q == DIR_LEFT) begin
                        if (led_q[NLED-1]) begin
                            led_q <= {1'b0, led_q[NLED-1:1]};
                            dir_q <= DIR_RIGHT;
                        end else begin
                            led_q <= {led_q[NLED-2:0], 1'b0};
                        end
                    end else begin
                        if (led_q[0]) begin
                            led_q <= {led_q[NLED-2:0], 1'b0};
                            dir_q <= DIR_LEFT;
                        end else begin
                            led_q <= {1'b0, led_q[NLED-1:1]};
                        end
                    end
                end
                default: begin
                    led_q <= led_q;
                end
            endcase
        end else begin
            led_q <= led_q;
        end
    end

    assign bus.LEDG     = led_q;
    assign bus.RATE_IDX = rate_q;
    assign bus.MODE     = mode_q;
    assign bus.RUNNING  = running_q;
    assign bus.TICK     = tick_q;

endmodule
